// File: rtl/spu32_bus_byteserializer.sv
// spu32_bus_byteserializer
//   Splits a CPU byte/halfword/fullword access into a little-endian sequence
//   of single-byte transactions on an 8-bit memory/peripheral bus.
//   Byte i goes to address addr+i (32-bit wrap) and carries data[8i+7:8i].
//
// Ports:
//   I_clk, I_reset          clock, asynchronous active-high reset
//   I_strobe .. I_data      CPU request (held stable while O_wait is high)
//   O_data, O_wait, O_err   CPU response: read data, wait, timeout flag
//   O_mem_*                 byte-bus request (addr, data, strobe, write)
//   I_mem_data, I_mem_ack   byte-bus response (data sampled on ack)
//
// Optional feature: define SPU32_BUSSER_TIMEOUT_EN to abort a byte that has
// not been acknowledged within TIMEOUT_CYCLES cycles (O_err=1 for the DONE
// cycle). Without it O_err is constant 0 and the bus waits for ack forever.
module spu32_bus_byteserializer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_strobe,
  input  logic        I_write,
  input  logic        I_halfword,
  input  logic        I_fullword,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_data,
  output logic [31:0] O_data,
  output logic        O_wait,
  output logic        O_err,
  output logic [31:0] O_mem_addr,
  output logic [7:0]  O_mem_data,
  output logic        O_mem_strobe,
  output logic        O_mem_write,
  input  logic [7:0]  I_mem_data,
  input  logic        I_mem_ack
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d, rbuf_upd;
  logic [31:0] data_q, data_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_data_q, mem_data_d;
  logic        mem_strobe_q, mem_strobe_d;
  logic        mem_write_q, mem_write_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [1:0]  last_q, last_d;   // index of the final byte (N-1)
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  idx_inc;
  logic [1:0]  req_last;

`ifdef SPU32_BUSSER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  // Fullword wins over halfword when both are set.
  assign req_last = I_fullword ? 2'd3 : (I_halfword ? 2'd1 : 2'd0);
  assign idx_inc  = idx_q + 2'd1;

  // Read buffer with the currently acknowledged byte merged in; writes leave
  // the (cleared) buffer untouched.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rbuf
    assign rbuf_upd[8*gi +: 8] = (!write_q && idx_q == 2'(gi)) ? I_mem_data
                                                              : rbuf_q[8*gi +: 8];
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    data_d       = data_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_strobe_d = mem_strobe_q;
    mem_write_d  = mem_write_q;
    write_d      = write_q;
    err_d        = err_q;
    last_d       = last_q;
    idx_d        = idx_q;
`ifdef SPU32_BUSSER_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (I_strobe) begin
          addr_d       = I_addr;
          wdata_d      = I_data;
          write_d      = I_write;
          last_d       = req_last;
          idx_d        = 2'd0;
          rbuf_d       = 32'd0;
          err_d        = 1'b0;
          mem_strobe_d = 1'b1;
          mem_addr_d   = I_addr;
          mem_data_d   = I_data[7:0];
          mem_write_d  = I_write;
`ifdef SPU32_BUSSER_TIMEOUT_EN
          cnt_d        = 16'd0;
`endif
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (I_mem_ack) begin
          rbuf_d = rbuf_upd;
          if (idx_q == last_q) begin
            mem_strobe_d = 1'b0;
            data_d       = rbuf_upd;
            state_d      = S_DONE;
          end else begin
            idx_d      = idx_inc;
            mem_addr_d = addr_q + {30'd0, idx_inc};   // wraps at 2^32
            mem_data_d = wdata_q[{idx_inc, 3'b000} +: 8];
`ifdef SPU32_BUSSER_TIMEOUT_EN
            cnt_d      = 16'd0;
`endif
          end
`ifdef SPU32_BUSSER_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          // Abort: O_data keeps its previous value.
          mem_strobe_d = 1'b0;
          err_d        = 1'b1;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      data_q       <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_strobe_q <= 1'b0;
      mem_write_q  <= 1'b0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      last_q       <= '0;
      idx_q        <= '0;
`ifdef SPU32_BUSSER_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      data_q       <= data_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_strobe_q <= mem_strobe_d;
      mem_write_q  <= mem_write_d;
      write_q      <= write_d;
      err_q        <= err_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
`ifdef SPU32_BUSSER_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign O_wait       = I_strobe && (state_q != S_DONE);
  assign O_data       = data_q;
  assign O_mem_addr   = mem_addr_q;
  assign O_mem_data   = mem_data_q;
  assign O_mem_strobe = mem_strobe_q;
  assign O_mem_write  = mem_write_q;
`ifdef SPU32_BUSSER_TIMEOUT_EN
  assign O_err        = err_q;
`else
  assign O_err        = 1'b0;
`endif

endmodule

// File: tb/tb_spu32_bus_byteserializer.sv
module tb_spu32_bus_byteserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0, wr = 1'b0, hw = 1'b0, fw = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] o_data;
  logic        o_wait, o_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_strobe, mem_write;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spu32_bus_byteserializer #(.TIMEOUT_CYCLES(8)) dut (
    .I_clk(clk), .I_reset(rst),
    .I_strobe(strobe), .I_write(wr), .I_halfword(hw), .I_fullword(fw),
    .I_addr(addr), .I_data(wdata),
    .O_data(o_data), .O_wait(o_wait), .O_err(o_err),
    .O_mem_addr(mem_addr), .O_mem_data(mem_wdata),
    .O_mem_strobe(mem_strobe), .O_mem_write(mem_write),
    .I_mem_data(mem_rdata), .I_mem_ack(mem_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        w, h, f;
    logic [31:0] a, wd, rbytes;
    int          stall;     // idle cycles before each ack
    int          nbytes;
    int          done_cyc;  // cycle index of DONE, strobe cycle = 0
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  // Runs one transaction; outputs sampled on the falling edge.
  task automatic run_txn(input vec_t v, input int id);
    int cyc = 0, bytes = 0, st = 0, done = -1;
    @(negedge clk);
    strobe = 1'b1; wr = v.w; hw = v.h; fw = v.f; addr = v.a;
    wdata = v.w ? v.wd : 32'hDEADBEEF;
    #1 check($sformatf("v%0d wait_at_start", id), {31'd0, o_wait}, 32'd1);
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (!o_wait) begin
        done = cyc;
        break;
      end
      if (mem_strobe) begin
        check($sformatf("v%0d addr b%0d", id, bytes), mem_addr, v.a + 32'(bytes));
        check($sformatf("v%0d write b%0d", id, bytes), {31'd0, mem_write}, {31'd0, v.w});
        if (v.w && bytes < 4)
          check($sformatf("v%0d wbyte b%0d", id, bytes), {24'd0, mem_wdata}, {24'd0, v.wd[8*bytes +: 8]});
        if (st == v.stall) begin
          mem_ack = 1'b1;
          mem_rdata = (bytes < 4) ? v.rbytes[8*bytes +: 8] : 8'hxx;
          bytes++;
          st = 0;
        end else begin
          st++;
        end
      end
    end
    check($sformatf("v%0d done_cycle", id), done, v.done_cyc);
    check($sformatf("v%0d nbytes", id), bytes, v.nbytes);
    check($sformatf("v%0d strobe_in_done", id), {31'd0, mem_strobe}, 32'd0);
    check($sformatf("v%0d err", id), {31'd0, o_err}, 32'd0);
    if (v.chk_data) check($sformatf("v%0d rdata", id), o_data, v.exp_data);
    $display("txn %0d: w=%0b n=%0d addr=%h done@%0d odata=%h", id, v.w, bytes, v.a, done, o_data);
    strobe = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           w     h     f     addr          wdata         rbytes        stl n  done chk  exp
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h00000100, 32'h0,        32'hFFFFFFA5, 0, 1, 2,  1'b1, 32'h000000A5};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h00000200, 32'h11223344, 32'h0,        0, 4, 5,  1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,        32'hEEEE1234, 0, 2, 3,  1'b1, 32'h00001234};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h00000300, 32'h0,        32'h89ABCDEF, 3, 4, 17, 1'b1, 32'h89ABCDEF};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h00001003, 32'hCAFEBABE, 32'h0,        0, 2, 3,  1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h00000007, 32'h0,        32'h0000005A, 1, 1, 3,  1'b1, 32'h0000005A};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h00000010, 32'hFFFFFF77, 32'h0,        0, 1, 2,  1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h00000020, 32'h0,        32'h01020304, 0, 4, 5,  1'b1, 32'h01020304};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst mem_strobe", {31'd0, mem_strobe}, 32'd0);
    check("rst mem_write", {31'd0, mem_write}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_data", {24'd0, mem_wdata}, 32'd0);
    check("rst odata", o_data, 32'd0);
    check("rst err", {31'd0, o_err}, 32'd0);
    check("rst wait", {31'd0, o_wait}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // O_data holds while idle
    repeat (3) @(negedge clk);
    check("hold odata", o_data, 32'h01020304);
    $display("hold: odata=%h", o_data);

    // Back-to-back: strobe held through DONE
    @(negedge clk);
    strobe = 1'b1; wr = 1'b0; hw = 1'b0; fw = 1'b0; addr = 32'h40;
    @(negedge clk);                       // cycle 1: byte presented
    check("b2b first strobe", {31'd0, mem_strobe}, 32'd1);
    check("b2b first addr", mem_addr, 32'h40);
    mem_ack = 1'b1; mem_rdata = 8'h11;
    @(negedge clk);                       // cycle 2: DONE
    mem_ack = 1'b0;
    check("b2b first done wait", {31'd0, o_wait}, 32'd0);
    check("b2b first odata", o_data, 32'h11);
    addr = 32'h41;
    @(negedge clk);                       // cycle 3: IDLE, new start
    check("b2b idle wait", {31'd0, o_wait}, 32'd1);
    @(negedge clk);                       // cycle 4
    check("b2b second strobe", {31'd0, mem_strobe}, 32'd1);
    check("b2b second addr", mem_addr, 32'h41);
    mem_ack = 1'b1; mem_rdata = 8'h22;
    @(negedge clk);
    mem_ack = 1'b0;
    check("b2b second done wait", {31'd0, o_wait}, 32'd0);
    check("b2b second odata", o_data, 32'h22);
    strobe = 1'b0;
    $display("b2b: odata=%h", o_data);

    // Reset pulsed while byte 2 of a fullword read is on the bus
    @(negedge clk);
    strobe = 1'b1; fw = 1'b1; addr = 32'h500;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 8'hA1;   // byte 0
    @(negedge clk); mem_rdata = 8'hA2;                   // byte 1
    @(negedge clk); mem_ack = 1'b0;                      // byte 2 on bus
    check("mid addr b2", mem_addr, 32'h502);
    strobe = 1'b0;
    rst = 1'b1;
    #1;
    check("mid rst strobe", {31'd0, mem_strobe}, 32'd0);
    check("mid rst odata", o_data, 32'd0);
    check("mid rst addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0; fw = 1'b0;
    repeat (2) @(negedge clk);
    check("post rst idle strobe", {31'd0, mem_strobe}, 32'd0);
    $display("reset mid-transfer: strobe=%0b odata=%h", mem_strobe, o_data);

`ifdef SPU32_BUSSER_TIMEOUT_EN
    // Timeout with no ack; first give O_data a known value
    begin
      vec_t t;
      int hi = 0, cyc = 0;
      t = '{1'b0, 1'b0, 1'b0, 32'h00000600, 32'h0, 32'h000000C3, 0, 1, 2, 1'b1, 32'h000000C3};
      run_txn(t, 100);
      @(negedge clk);
      strobe = 1'b1; addr = 32'h604;
      while (cyc < 50) begin
        @(negedge clk);
        cyc++;
        if (!o_wait) break;
        if (mem_strobe) hi++;
      end
      check("to strobe cycles", hi, 8);
      check("to err", {31'd0, o_err}, 32'd1);
      check("to wait", {31'd0, o_wait}, 32'd0);
      check("to odata kept", o_data, 32'h000000C3);
      @(negedge clk);                     // IDLE, new start with strobe held
      @(negedge clk);
      check("to err cleared", {31'd0, o_err}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 8'h3C;
      @(negedge clk);
      mem_ack = 1'b0;
      strobe = 1'b0;
      check("to retry odata", o_data, 32'h0000003C);
      $display("timeout: strobe_cycles=%0d", hi);
    end
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
